wb_protocol_checker: RTL and testbench

Synthesizable Wishbone classic bus protocol checker, parametrised in address and data width. It passively monitors one master port (e.g. core-to-fabric) and flags protocol violations with sticky error bits and an interrupt. It also captures the first offending transfer and keeps read/write counts and the worst-case ack latency. It is used both in simulation and in FPGA builds where SVA is not available, and never drives the bus.

---
 rtl/wb_chk_pkg.sv | 29 ++
 rtl/wb_chk_sat_cnt.sv | 21 ++
 rtl/wb_protocol_checker.sv | 175 +++++++++++++++++
 tb/tb_wb_protocol_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_chk_pkg.sv
// Shared definitions for the Wishbone classic protocol checker:
// error bit indices, FSM state type and a priority helper.
package wb_chk_pkg;

    localparam int ERR_STB_NO_CYC   = 0;
    localparam int ERR_ACK_NO_STB   = 1;
    localparam int ERR_REQ_UNSTABLE = 2;
    localparam int ERR_TIMEOUT      = 3;
    localparam int ERR_CYC_ABORT    = 4;
    localparam int NUM_ERR          = 5;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    // Lowest set bit wins, so simultaneous errors report the lowest index.
    function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] err);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (err[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_chk_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones
// instead of wrapping.
module wb_chk_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_protocol_checker.sv
// Passive Wishbone classic master-port monitor: sticky protocol error
// flags, first-error capture, transfer counters and worst ack latency.
module wb_protocol_checker
    import wb_chk_pkg::*;
#(
    parameter int  ADR_WIDTH = 32,
    parameter int  DAT_WIDTH = 32,
    parameter int  TIMEOUT   = 256,
    parameter int  CNT_WIDTH = 16,
    localparam int SEL_WIDTH = DAT_WIDTH / 8,
    localparam int LAT_WIDTH = $clog2(TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [ADR_WIDTH-1:0] i_wb_adr,
    input  logic [SEL_WIDTH-1:0] i_wb_sel,
    input  logic [DAT_WIDTH-1:0] i_wb_dat,
    input  logic                 i_wb_ack,
    output logic [NUM_ERR-1:0]   o_err_sticky,
    output logic [NUM_ERR-1:0]   o_err_pulse,
    output logic                 o_irq,
    output logic [2:0]           o_first_code,
    output logic [ADR_WIDTH-1:0] o_first_adr,
    output logic [CNT_WIDTH-1:0] o_rd_count,
    output logic [CNT_WIDTH-1:0] o_wr_count,
    output logic [LAT_WIDTH-1:0] o_max_latency
);

    localparam logic [LAT_WIDTH-1:0] LAT_TIMEOUT = LAT_WIDTH'(TIMEOUT);
    localparam logic [LAT_WIDTH-1:0] LAT_MAX     = '1;

    state_t               state;
    state_t               state_next;
    logic                 req;
    logic                 complete;
    logic                 complete_we;
    logic [LAT_WIDTH-1:0] lat;
    logic [LAT_WIDTH-1:0] done_lat;
    logic                 timed_out;
    logic [NUM_ERR-1:0]   err_det;
    logic [ADR_WIDTH-1:0] cap_adr;
    logic [SEL_WIDTH-1:0] cap_sel;
    logic [DAT_WIDTH-1:0] cap_dat;
    logic                 cap_we;

    assign req   = i_wb_cyc & i_wb_stb;
    assign o_irq = |o_err_sticky;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        complete    = 1'b0;
        complete_we = i_wb_we;
        done_lat    = LAT_WIDTH'(1);
        err_det     = '0;
        err_det[ERR_STB_NO_CYC] = i_wb_stb & ~i_wb_cyc;
        err_det[ERR_ACK_NO_STB] = i_wb_ack & ~req;
        case (state)
            IDLE: begin
                if (req) begin
                    if (i_wb_ack) begin
                        complete = 1'b1;
                    end else begin
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                err_det[ERR_REQ_UNSTABLE] = (i_wb_adr != cap_adr) | (i_wb_we != cap_we)
                                          | (i_wb_sel != cap_sel)
                                          | (cap_we & (i_wb_dat != cap_dat));
                err_det[ERR_TIMEOUT]   = ~i_wb_ack & ~timed_out & (lat == LAT_TIMEOUT);
                err_det[ERR_CYC_ABORT] = ~req & ~i_wb_ack;
                complete_we = cap_we;
                done_lat    = (lat == LAT_MAX) ? LAT_MAX : lat + LAT_WIDTH'(1);
                // An ack without request is already flagged; it still ends the transfer.
                if (req && i_wb_ack) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (!req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_adr   <= '0;
            cap_sel   <= '0;
            cap_dat   <= '0;
            cap_we    <= 1'b0;
            lat       <= '0;
            timed_out <= 1'b0;
        end else if (state == IDLE) begin
            if (state_next == PEND) begin
                cap_adr   <= i_wb_adr;
                cap_sel   <= i_wb_sel;
                cap_dat   <= i_wb_dat;
                cap_we    <= i_wb_we;
                lat       <= LAT_WIDTH'(1);
                timed_out <= 1'b0;
            end
        end else if (state_next == IDLE) begin
            lat       <= '0;
            timed_out <= 1'b0;
        end else begin
            if (lat != LAT_TIMEOUT) begin
                lat <= lat + LAT_WIDTH'(1);
            end
            if (err_det[ERR_TIMEOUT]) begin
                timed_out <= 1'b1;
            end
        end
    end

    // A clear in the same cycle as a new error lets that error become the first one.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_err_pulse   <= '0;
            o_err_sticky  <= '0;
            o_first_code  <= '0;
            o_first_adr   <= '0;
            o_max_latency <= '0;
        end else begin
            o_err_pulse  <= err_det;
            o_err_sticky <= i_clear ? err_det : (o_err_sticky | err_det);
            if ((i_clear || (o_err_sticky == '0)) && (err_det != '0)) begin
                o_first_code <= lowest_err(err_det);
                o_first_adr  <= i_wb_adr;
            end else if (i_clear) begin
                o_first_code <= '0;
                o_first_adr  <= '0;
            end
            if (i_clear) begin
                o_max_latency <= '0;
            end else if (complete && (done_lat > o_max_latency)) begin
                o_max_latency <= done_lat;
            end
        end
    end

    wb_chk_sat_cnt #(
        .WIDTH(CNT_WIDTH)
    ) u_rd_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(i_clear),
        .inc  (complete & ~complete_we),
        .count(o_rd_count)
    );

    wb_chk_sat_cnt #(
        .WIDTH(CNT_WIDTH)
    ) u_wr_cnt (
        .clk  (clk),
        .reset(reset),
        .clear(i_clear),
        .inc  (complete & complete_we),
        .count(o_wr_count)
    );

endmodule

// File: tb/tb_wb_protocol_checker.sv
// Directed bench for wb_protocol_checker with a transfer-level reference
// model compared every cycle, plus hand-computed spot checks.
module tb_wb_protocol_checker;

    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 32;
    localparam int TIMEOUT   = 8;
    localparam int CNT_WIDTH = 4;
    localparam int SEL_WIDTH = DAT_WIDTH / 8;
    localparam int LAT_WIDTH = $clog2(TIMEOUT + 1);
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

    logic                 clk;
    logic                 reset;
    logic                 clear;
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADR_WIDTH-1:0] adr;
    logic [SEL_WIDTH-1:0] sel;
    logic [DAT_WIDTH-1:0] dat;
    logic                 ack;
    logic [4:0]           err_sticky;
    logic [4:0]           err_pulse;
    logic                 irq;
    logic [2:0]           first_code;
    logic [ADR_WIDTH-1:0] first_adr;
    logic [CNT_WIDTH-1:0] rd_count;
    logic [CNT_WIDTH-1:0] wr_count;
    logic [LAT_WIDTH-1:0] max_latency;

    int errors;
    int checks;

    // Reference model state: the outstanding transfer and the expected outputs.
    bit                   m_pend;
    bit                   m_to_seen;
    int                   m_elapsed;
    logic [ADR_WIDTH-1:0] m_adr;
    logic [SEL_WIDTH-1:0] m_sel;
    logic [DAT_WIDTH-1:0] m_dat;
    logic                 m_we;
    bit                   model_valid;
    logic [4:0]           exp_pulse;
    logic [4:0]           exp_sticky;
    logic [2:0]           exp_code;
    logic [ADR_WIDTH-1:0] exp_adr;
    int                   exp_rd;
    int                   exp_wr;
    int                   exp_max;

    wb_protocol_checker #(
        .ADR_WIDTH(ADR_WIDTH),
        .DAT_WIDTH(DAT_WIDTH),
        .TIMEOUT  (TIMEOUT),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (clear),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_adr     (adr),
        .i_wb_sel     (sel),
        .i_wb_dat     (dat),
        .i_wb_ack     (ack),
        .o_err_sticky (err_sticky),
        .o_err_pulse  (err_pulse),
        .o_irq        (irq),
        .o_first_code (first_code),
        .o_first_adr  (first_adr),
        .o_rd_count   (rd_count),
        .o_wr_count   (wr_count),
        .o_max_latency(max_latency)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model by one sampled clock edge, working from transfer-level rules.
    task automatic model_step();
        logic [4:0] e;
        bit         r;
        bit         done;
        int         dlat;
        logic       dwe;
        model_valid = 1'b1;
        if (reset) begin
            m_pend = 0; m_to_seen = 0; m_elapsed = 0;
            exp_pulse = '0; exp_sticky = '0; exp_code = '0; exp_adr = '0;
            exp_rd = 0; exp_wr = 0; exp_max = 0;
        end else begin
            r    = cyc && stb;
            e    = '0;
            done = 0;
            dlat = 0;
            dwe  = 1'b0;
            e[0] = stb && !cyc;
            e[1] = ack && !r;
            if (m_pend) begin
                e[2] = (adr != m_adr) || (we != m_we) || (sel != m_sel) || (m_we && (dat != m_dat));
                if (!ack && !m_to_seen && (m_elapsed >= TIMEOUT)) begin
                    e[3] = 1'b1;
                    m_to_seen = 1;
                end
                e[4] = !r && !ack;
                if (r && ack) begin
                    done = 1;
                    dlat = ((m_elapsed < TIMEOUT) ? m_elapsed : TIMEOUT) + 1;
                    dwe  = m_we;
                end
                if (!r || ack) m_pend = 0;
                else m_elapsed++;
            end else if (r) begin
                if (ack) begin
                    done = 1; dlat = 1; dwe = we;
                end else begin
                    m_pend = 1; m_elapsed = 1; m_to_seen = 0;
                    m_adr = adr; m_sel = sel; m_dat = dat; m_we = we;
                end
            end
            exp_pulse = e;
            if ((clear || exp_sticky == '0) && e != '0) begin
                exp_adr = adr;
                for (int i = 0; i < 5; i++) begin
                    if (e[i]) begin
                        exp_code = 3'(i);
                        break;
                    end
                end
            end else if (clear) begin
                exp_code = '0;
                exp_adr  = '0;
            end
            exp_sticky = clear ? e : (exp_sticky | e);
            if (clear) begin
                exp_rd = 0; exp_wr = 0; exp_max = 0;
            end else if (done) begin
                if (dwe) exp_wr = (exp_wr < CNT_MAX) ? exp_wr + 1 : CNT_MAX;
                else     exp_rd = (exp_rd < CNT_MAX) ? exp_rd + 1 : CNT_MAX;
                if (dlat > exp_max) exp_max = dlat;
            end
        end
    endtask

    task automatic apply_stimulus(input logic c, input logic s, input logic w,
                                  input logic [ADR_WIDTH-1:0] a, input logic [SEL_WIDTH-1:0] se,
                                  input logic [DAT_WIDTH-1:0] d, input logic k, input logic clr);
        cyc = c; stb = s; we = w; adr = a; sel = se; dat = d; ack = k; clear = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_cycle(input logic clr);
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, clr);
    endtask

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check_output("pulse",       64'(err_pulse),   64'(exp_pulse));
                check_output("sticky",      64'(err_sticky),  64'(exp_sticky));
                check_output("irq",         64'(irq),         64'(exp_sticky != '0));
                check_output("first_code",  64'(first_code),  64'(exp_code));
                check_output("first_adr",   64'(first_adr),   64'(exp_adr));
                check_output("rd_count",    64'(rd_count),    64'(exp_rd));
                check_output("wr_count",    64'(wr_count),    64'(exp_wr));
                check_output("max_latency", 64'(max_latency), 64'(exp_max));
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        model_valid = 0;
        reset = 1'b1;
        repeat (3) idle_cycle(1'b0);
        check_output("reset_sticky", 64'(err_sticky), 64'd0);
        check_output("reset_rd", 64'(rd_count), 64'd0);
        reset = 1'b0;

        $display("[TB] read with three wait states");
        repeat (3) apply_stimulus(1, 1, 0, 32'h100, 4'hf, '0, 0, 0);
        apply_stimulus(1, 1, 0, 32'h100, 4'hf, '0, 1, 0);
        check_output("t1_rd", 64'(rd_count), 64'd1);
        check_output("t1_lat", 64'(max_latency), 64'd4);
        check_output("t1_sticky", 64'(err_sticky), 64'd0);
        idle_cycle(1'b0);

        $display("[TB] zero-wait write then read");
        idle_cycle(1'b1);
        apply_stimulus(1, 1, 1, 32'h10, 4'hf, 32'hdeadbeef, 1, 0);
        apply_stimulus(1, 1, 0, 32'h14, 4'hf, '0, 1, 0);
        check_output("t2_wr", 64'(wr_count), 64'd1);
        check_output("t2_rd", 64'(rd_count), 64'd1);
        check_output("t2_lat", 64'(max_latency), 64'd1);
        check_output("t2_sticky", 64'(err_sticky), 64'd0);
        idle_cycle(1'b0);

        $display("[TB] timeout then abort");
        idle_cycle(1'b1);
        repeat (8) apply_stimulus(1, 1, 0, 32'h300, 4'hf, '0, 0, 0);
        check_output("t3_pre_pulse", 64'(err_pulse), 64'd0);
        apply_stimulus(1, 1, 0, 32'h300, 4'hf, '0, 0, 0);
        check_output("t3_pulse", 64'(err_pulse), 64'b01000);
        check_output("t3_code", 64'(first_code), 64'd3);
        check_output("t3_adr", 64'(first_adr), 64'h300);
        apply_stimulus(1, 1, 0, 32'h300, 4'hf, '0, 0, 0);
        check_output("t3_once", 64'(err_pulse), 64'd0);
        apply_stimulus(0, 0, 0, 32'h300, 4'hf, '0, 0, 0);
        check_output("t3_abort", 64'(err_sticky), 64'b11000);
        check_output("t3_code2", 64'(first_code), 64'd3);

        $display("[TB] unstable address, clear, clear with new error");
        idle_cycle(1'b1);
        apply_stimulus(1, 1, 0, 32'h200, 4'hf, '0, 0, 0);
        apply_stimulus(1, 1, 0, 32'h204, 4'hf, '0, 0, 0);
        check_output("t4_sticky", 64'(err_sticky), 64'b00100);
        check_output("t4_irq", 64'(irq), 64'd1);
        apply_stimulus(1, 1, 0, 32'h200, 4'hf, '0, 1, 0);
        idle_cycle(1'b1);
        check_output("t4_clr_sticky", 64'(err_sticky), 64'd0);
        check_output("t4_clr_rd", 64'(rd_count), 64'd0);
        check_output("t4_clr_adr", 64'(first_adr), 64'd0);
        apply_stimulus(0, 0, 0, 32'h60, '0, '0, 1, 0);
        check_output("t4_code1", 64'(first_code), 64'd1);
        apply_stimulus(0, 1, 0, 32'h44, '0, '0, 0, 1);
        check_output("t4_clr_new", 64'(err_sticky), 64'b00001);
        check_output("t4_clr_code", 64'(first_code), 64'd0);
        check_output("t4_clr_adr2", 64'(first_adr), 64'h44);

        $display("[TB] ack without request plus stb without cyc");
        idle_cycle(1'b1);
        apply_stimulus(0, 1, 0, 32'h88, '0, '0, 1, 0);
        check_output("t5_sticky", 64'(err_sticky), 64'b00011);
        check_output("t5_code", 64'(first_code), 64'd0);

        $display("[TB] write data change while pending");
        idle_cycle(1'b1);
        apply_stimulus(1, 1, 1, 32'h400, 4'hf, 32'h11, 0, 0);
        apply_stimulus(1, 1, 1, 32'h400, 4'hf, 32'h22, 1, 0);
        check_output("t6_pulse", 64'(err_pulse), 64'b00100);
        check_output("t6_wr", 64'(wr_count), 64'd1);

        $display("[TB] write counter saturation");
        idle_cycle(1'b1);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1, 1, 1, 32'h1000 + 32'(4 * i), 4'hf, 32'(i), 1, 0);
        end
        check_output("t7_wr_sat", 64'(wr_count), 64'd15);
        check_output("t7_rd", 64'(rd_count), 64'd0);

        $display("[TB] reset during pending transfer");
        repeat (3) apply_stimulus(1, 1, 0, 32'h500, 4'hf, '0, 0, 0);
        reset = 1'b1;
        apply_stimulus(1, 1, 0, 32'h500, 4'hf, '0, 0, 0);
        idle_cycle(1'b0);
        check_output("t8_wr", 64'(wr_count), 64'd0);
        check_output("t8_sticky", 64'(err_sticky), 64'd0);
        reset = 1'b0;
        repeat (3) idle_cycle(1'b0);
        check_output("t8_no_abort", 64'(err_sticky), 64'd0);
        check_output("t8_irq", 64'(irq), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
